alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Operand/control stage directly upstream of the ALU function units (alu_rol, alu_ror, adder, logic).
//  Latches operands (Y <- a_in, B <- b_in) on a start request and drives the units. Rotate and shift
//  counts are taken from B[4:0]. Captures the selected result into the 64-bit Z pair (z_hi:z_lo).
//  Sequences the multi-cycle signed MUL and DIV ops. Presents a start/busy/done handshake to control.
// PARAMETERS
//  WIDTH      32  operand width; the rotate/shift count field is $clog2(WIDTH) bits
//  ITERS      32  MUL/DIV iteration count; must equal WIDTH
// PORTS
//  clock      in   1      single clock, all state changes on rising edge
//  clear_n    in   1      synchronous active-low reset
//  start      in   1      request; sampled only in IDLE
//  opcode     in   4      0 ADD,1 SUB,2 AND,3 OR,4 SHR,5 SHRA,6 SHL,7 ROR,8 ROL,9 NEG,A NOT,B MUL,C DIV
//  a_in       in   32     operand A (Y)
//  b_in       in   32     operand B
//  busy       out  1      high from the cycle after an accepted start until done
//  done       out  1      one-cycle pulse; z_hi/z_lo valid from this cycle until the next accepted start
//  z_lo       out  32     low result word / quotient
//  z_hi       out  32     high result word / remainder (0 for single-cycle ops)
//  err        out  1      set with done: illegal opcode (D-F) or divide by zero
// BEHAVIOUR
//  - Reset (clear_n=0 at an edge): state IDLE; busy, done and err = 0; z_lo and z_hi = 0; Y and B = 0.
//    Reset overrides any in-flight op, and no done is produced for that op.
//  - FSM states: IDLE, EXEC, ITER, FIX, DONE.
//  - IDLE, start=1 at edge N: latch opcode/a_in/b_in, busy=1.
//    MUL/DIV go to ITER; all other opcodes go to EXEC.
//  - EXEC: compute combinationally from the latched Y/B. z_lo <= result, z_hi <= 0. Go to DONE.
//    done=1 at cycle N+2, so single-cycle latency is 2 edges.
//  - ITER: runs ITERS cycles.
//    MUL: radix-2 signed shift-add on |Y|,|B|.
//    DIV: restoring division on |Y|/|B|.
//    Iteration count wraps 0..ITERS-1, then go to FIX.
//  - FIX: apply signs.
//    MUL: z_hi:z_lo = signed 64-bit product.
//    DIV: quotient truncates toward zero; remainder takes the sign of the dividend.
//    Then go to DONE. MUL/DIV done=1 at cycle N+ITERS+3.
//  - DONE: done=1 for exactly one cycle, busy=0. Next state IDLE.
//    start in the DONE cycle is ignored; a new start is accepted the following cycle.
//  - start while busy is ignored. a_in/b_in changes after acceptance have no effect.
//  - ADD/SUB/NEG wrap mod 2^32 with no overflow flag. NEG = 0 - Y. NOT = ~Y.
//  - Shifts and rotates use B[4:0], so a count of 32 behaves as 0.
//    SHRA sign-fills. ROR/ROL use the alu_ror/alu_rol instances.
//  - DIV with B=0: skip ITER. z_lo = 32'hFFFFFFFF, z_hi = Y, err = 1, latency as EXEC.
//  - Illegal opcode: z_lo = z_hi = 0, err = 1, latency as EXEC.
//  - MUL of 32'h80000000 x 32'h80000000 gives z_hi:z_lo = 64'h4000000000000000.
//  - DIV of 32'h80000000 / -1 gives z_lo = 32'h80000000, z_hi = 0, err = 0.
// CONFIGURATION
//  ALU_DIV_EN defined: DIV is implemented as described above.
//  ALU_DIV_EN undefined: no divider logic. Opcode C is treated as illegal (err=1, z=0, EXEC latency).
// TESTING
//  1 clear_n=0 for 2 clocks during a running MUL -> busy=0, done=0, z_lo=z_hi=0; no done pulse follows.
//  2 ROL Y=32'h3, B=31 -> done at N+2, z_lo=32'h80000001.
//    ROR Y=32'h3, B=1 -> z_lo=32'h80000001.
//    Sweep B=0..31 and check against a reference model.
//  3 MUL Y=-7 (32'hFFFFFFF9), B=6 -> done at N+35, z_hi=32'hFFFFFFFF, z_lo=32'hFFFFFFD6.
//    start pulsed mid-op -> ignored.
//  4 DIV Y=-17, B=5 -> z_lo=-3 (32'hFFFFFFFD), z_hi=-2 (32'hFFFFFFFE), err=0.
//    DIV Y=9, B=0 -> N+2, z_lo=32'hFFFFFFFF, z_hi=9, err=1.
//  5 SHRA Y=32'h80000000, B=4 -> z_lo=32'hF8000000.
//    SHL Y=1, B=32 -> z_lo=1.
//    opcode E -> err=1, z=0.
//  6 Back-to-back: start held high continuously -> ops accepted one cycle after each done;
//    exactly one done per op.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: latches Y/B on start, runs single-cycle ALU ops or ITERS-step signed MUL/DIV into z_hi:z_lo.
// Latency: done 2 edges after the accepting edge for single-cycle ops, ITERS+3 for MUL/DIV.
// Backpressure: start is ignored while busy and in the done cycle. Define ALU_DIV_EN to build the divider.
module alu_op_sequencer #(
    parameter int WIDTH = 32,
    parameter int ITERS = 32
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             start,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] z_lo,
    output logic [WIDTH-1:0] z_hi,
    output logic             err
);
    localparam int SW = $clog2(WIDTH);
    localparam int CW = $clog2(ITERS);

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_SHR  = 4'h4;
    localparam logic [3:0] OP_SHRA = 4'h5;
    localparam logic [3:0] OP_SHL  = 4'h6;
    localparam logic [3:0] OP_ROR  = 4'h7;
    localparam logic [3:0] OP_ROL  = 4'h8;
    localparam logic [3:0] OP_NEG  = 4'h9;
    localparam logic [3:0] OP_NOT  = 4'hA;
    localparam logic [3:0] OP_MUL  = 4'hB;
    localparam logic [3:0] OP_DIV  = 4'hC;

    typedef enum logic [2:0] {IDLE, EXEC, ITER, FIX, DONE} state_t;

    state_t           state_q, state_d;
    logic             busy_q, busy_d, done_q, done_d, err_q, err_d, prep_q, prep_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] y_q, y_d, b_q, b_d;
    logic [WIDTH-1:0] z_lo_q, z_lo_d, z_hi_q, z_hi_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, mcand_q, mcand_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [SW-1:0]      sh;
    logic [WIDTH-1:0]   rol_res, ror_res, y_abs, b_abs;
    logic [WIDTH-1:0]   exec_lo, exec_hi, step_hi, step_lo;
    logic               exec_err, start_iter, op_is_mul;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod_mag, prod_signed;

    assign sh        = b_q[SW-1:0];
    assign y_abs     = y_q[WIDTH-1] ? -y_q : y_q;
    assign b_abs     = b_q[WIDTH-1] ? -b_q : b_q;
    assign op_is_mul = (op_q == OP_MUL);

    alu_rol #(.WIDTH(WIDTH)) u_rol (.din(y_q), .sh(sh), .dout(rol_res));
    alu_ror #(.WIDTH(WIDTH)) u_ror (.din(y_q), .sh(sh), .dout(ror_res));

    // Shift-add step: multiplier sits in acc_lo and is consumed LSB first.
    assign mul_sum     = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : '0);
    assign prod_mag    = {acc_hi_q, acc_lo_q};
    assign prod_signed = (y_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -prod_mag : prod_mag;

`ifdef ALU_DIV_EN
    logic [WIDTH:0]   div_rsh, div_diff;
    logic [WIDTH-1:0] quo_signed, rem_signed;

    assign start_iter = (opcode == OP_MUL) || ((opcode == OP_DIV) && (b_in != '0));
    assign div_rsh    = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign div_diff   = div_rsh - {1'b0, mcand_q};
    assign quo_signed = (y_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -acc_lo_q : acc_lo_q;
    assign rem_signed = y_q[WIDTH-1] ? -acc_hi_q : acc_hi_q;

    always_comb begin
        if (op_is_mul) begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end else if (!div_diff[WIDTH]) begin
            step_hi = div_diff[WIDTH-1:0];
            step_lo = {acc_lo_q[WIDTH-2:0], 1'b1};
        end else begin
            step_hi = div_rsh[WIDTH-1:0];
            step_lo = {acc_lo_q[WIDTH-2:0], 1'b0};
        end
    end
`else
    assign start_iter = (opcode == OP_MUL);
    assign step_hi    = mul_sum[WIDTH:1];
    assign step_lo    = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
`endif

    always_comb begin
        exec_lo  = '0;
        exec_hi  = '0;
        exec_err = 1'b0;
        case (op_q)
            OP_ADD:  exec_lo = y_q + b_q;
            OP_SUB:  exec_lo = y_q - b_q;
            OP_AND:  exec_lo = y_q & b_q;
            OP_OR:   exec_lo = y_q | b_q;
            OP_SHR:  exec_lo = y_q >> sh;
            OP_SHRA: exec_lo = $signed(y_q) >>> sh;
            OP_SHL:  exec_lo = y_q << sh;
            OP_ROR:  exec_lo = ror_res;
            OP_ROL:  exec_lo = rol_res;
            OP_NEG:  exec_lo = -y_q;
            OP_NOT:  exec_lo = ~y_q;
`ifdef ALU_DIV_EN
            // Only a zero divisor reaches EXEC with DIV.
            OP_DIV: begin
                exec_lo  = '1;
                exec_hi  = y_q;
                exec_err = 1'b1;
            end
`endif
            default: exec_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;
        prep_d   = prep_q;
        op_d     = op_q;
        y_d      = y_q;
        b_d      = b_q;
        z_lo_d   = z_lo_q;
        z_hi_d   = z_hi_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        mcand_d  = mcand_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    y_d     = a_in;
                    b_d     = b_in;
                    op_d    = opcode;
                    busy_d  = 1'b1;
                    prep_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = start_iter ? ITER : EXEC;
                end
            end
            EXEC: begin
                z_lo_d  = exec_lo;
                z_hi_d  = exec_hi;
                err_d   = exec_err;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = DONE;
            end
            ITER: begin
                // First ITER cycle registers operand magnitudes so the negate stays off the step path.
                if (prep_q) begin
                    prep_d   = 1'b0;
                    acc_hi_d = '0;
                    acc_lo_d = op_is_mul ? b_abs : y_abs;
                    mcand_d  = op_is_mul ? y_abs : b_abs;
                end else begin
                    acc_hi_d = step_hi;
                    acc_lo_d = step_lo;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == CW'(ITERS - 1)) begin
                        cnt_d   = '0;
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
`ifdef ALU_DIV_EN
                if (op_is_mul) begin
                    z_hi_d = prod_signed[2*WIDTH-1:WIDTH];
                    z_lo_d = prod_signed[WIDTH-1:0];
                end else begin
                    z_hi_d = rem_signed;
                    z_lo_d = quo_signed;
                end
`else
                z_hi_d = prod_signed[2*WIDTH-1:WIDTH];
                z_lo_d = prod_signed[WIDTH-1:0];
`endif
                err_d   = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            prep_q   <= 1'b0;
            op_q     <= '0;
            y_q      <= '0;
            b_q      <= '0;
            z_lo_q   <= '0;
            z_hi_q   <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            mcand_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            prep_q   <= prep_d;
            op_q     <= op_d;
            y_q      <= y_d;
            b_q      <= b_d;
            z_lo_q   <= z_lo_d;
            z_hi_q   <= z_hi_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            mcand_q  <= mcand_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;
    assign z_lo = z_lo_q;
    assign z_hi = z_hi_q;
endmodule

// alu_rol: rotate left by sh; counts wrap modulo WIDTH.
// Latency: combinational.
// Backpressure: none.
module alu_rol #(
    parameter int WIDTH = 32,
    parameter int SW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] din,
    input  logic [SW-1:0]    sh,
    output logic [WIDTH-1:0] dout
);
    logic [SW:0] inv;

    assign inv  = (SW+1)'(WIDTH) - {1'b0, sh};
    assign dout = (din << sh) | (din >> inv);
endmodule

// alu_ror: rotate right by sh; counts wrap modulo WIDTH.
// Latency: combinational.
// Backpressure: none.
module alu_ror #(
    parameter int WIDTH = 32,
    parameter int SW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] din,
    input  logic [SW-1:0]    sh,
    output logic [WIDTH-1:0] dout
);
    logic [SW:0] inv;

    assign inv  = (SW+1)'(WIDTH) - {1'b0, sh};
    assign dout = (din >> sh) | (din << inv);
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: reset, rotates, DIV (either build), MUL, single-cycle ops, illegal, back-to-back.
`timescale 1ns/1ps
module tb_alu_op_sequencer;
    logic        clock = 1'b0;
    logic        clear_n, start, busy, done, err;
    logic [3:0]  opcode;
    logic [31:0] a_in, b_in, z_lo, z_hi;
    int          n_checks = 0;
    int          n_fail   = 0;

    alu_op_sequencer dut (
        .clock(clock), .clear_n(clear_n), .start(start), .opcode(opcode),
        .a_in(a_in), .b_in(b_in), .busy(busy), .done(done),
        .z_lo(z_lo), .z_hi(z_hi), .err(err)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] rol_ref(input logic [31:0] x, input int n);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) r[(i + n) % 32] = x[i];
        return r;
    endfunction

    function automatic logic [31:0] ror_ref(input logic [31:0] x, input int n);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) r[i] = x[(i + n) % 32];
        return r;
    endfunction

    // Stimulus only: waits one edge (so the FSM is back in IDLE), issues one op, measures latency.
    // lat is the accept-edge-relative edge at which done is first sampled high; -1 on timeout.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int poke_at, output int lat, output logic bsy_start, output logic bsy_done);
        @(posedge clock); #1;
        opcode = op; a_in = a; b_in = b; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0; opcode = 4'h0; a_in = $urandom; b_in = $urandom;
        bsy_start = busy;
        bsy_done  = 1'b1;
        lat       = -1;
        for (int c = 1; c <= 100; c++) begin
            start = (c == poke_at);
            @(posedge clock); #1;
            if (done) begin
                lat = c + 1;
                bsy_done = busy;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        int lat, ndone;
        logic bs, bd;
        clear_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        n_checks++; if ({busy, done, err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {busy, done, err}); end
        n_checks++; if ({z_hi, z_lo} !== 64'h0) begin n_fail++; $display("FAIL reset_z: got %h expected 0", {z_hi, z_lo}); end
        clear_n = 1'b1;
        run_op(4'h0, 32'h5, 32'h6, 0, lat, bs, bd);
        n_checks++; if (z_lo !== 32'hB) begin n_fail++; $display("FAIL pre_reset_add: got %h expected 0000000b", z_lo); end
        @(posedge clock); #1;
        opcode = 4'hB; a_in = 32'h1234_5678; b_in = 32'h9; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mul_running_busy: got %b expected 1", busy); end
        clear_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        n_checks++; if ({busy, done, err} !== 3'b000) begin n_fail++; $display("FAIL midop_reset_flags: got %b expected 000", {busy, done, err}); end
        n_checks++; if ({z_hi, z_lo} !== 64'h0) begin n_fail++; $display("FAIL midop_reset_z: got %h expected 0", {z_hi, z_lo}); end
        clear_n = 1'b1;
        ndone = 0;
        repeat (50) begin
            @(posedge clock); #1;
            if (done) ndone++;
        end
        n_checks++; if (ndone !== 0) begin n_fail++; $display("FAIL no_done_after_reset: got %0d pulses expected 0", ndone); end
    endtask

    task automatic test_rotate();
        int lat;
        logic bs, bd;
        logic [31:0] x;
        run_op(4'h8, 32'h3, 32'd31, 0, lat, bs, bd);
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL rol_latency: got %0d expected 2", lat); end
        n_checks++; if (z_lo !== 32'h8000_0001) begin n_fail++; $display("FAIL rol_3_31: got %h expected 80000001", z_lo); end
        n_checks++; if ({bs, bd} !== 2'b10) begin n_fail++; $display("FAIL rol_busy: got %b expected 10", {bs, bd}); end
        run_op(4'h7, 32'h3, 32'd1, 0, lat, bs, bd);
        n_checks++; if (z_lo !== 32'h8000_0001) begin n_fail++; $display("FAIL ror_3_1: got %h expected 80000001", z_lo); end
        x = 32'hC000_1235;
        for (int n = 0; n < 32; n++) begin
            run_op(4'h8, x, n, 0, lat, bs, bd);
            n_checks++; if (z_lo !== rol_ref(x, n)) begin n_fail++; $display("FAIL rol_sweep[%0d]: got %h expected %h", n, z_lo, rol_ref(x, n)); end
            run_op(4'h7, x, n, 0, lat, bs, bd);
            n_checks++; if (z_lo !== ror_ref(x, n)) begin n_fail++; $display("FAIL ror_sweep[%0d]: got %h expected %h", n, z_lo, ror_ref(x, n)); end
        end
    endtask

    task automatic test_div();
        int lat;
        logic bs, bd;
`ifdef ALU_DIV_EN
        run_op(4'hC, 32'hFFFF_FFEF, 32'd5, 0, lat, bs, bd);
        n_checks++; if (lat !== 35) begin n_fail++; $display("FAIL div_latency: got %0d expected 35", lat); end
        n_checks++; if ({z_hi, z_lo, err} !== {32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0}) begin n_fail++; $display("FAIL div_m17_5: got %h %h err %b expected fffffffe fffffffd err 0", z_hi, z_lo, err); end
        run_op(4'hC, 32'd9, 32'd0, 0, lat, bs, bd);
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL div0_latency: got %0d expected 2", lat); end
        n_checks++; if ({z_hi, z_lo, err} !== {32'd9, 32'hFFFF_FFFF, 1'b1}) begin n_fail++; $display("FAIL div0: got %h %h err %b expected 00000009 ffffffff err 1", z_hi, z_lo, err); end
        run_op(4'hC, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, bs, bd);
        n_checks++; if ({z_hi, z_lo, err} !== {32'h0, 32'h8000_0000, 1'b0}) begin n_fail++; $display("FAIL div_min_m1: got %h %h err %b expected 00000000 80000000 err 0", z_hi, z_lo, err); end
        run_op(4'hC, 32'd100, 32'd7, 0, lat, bs, bd);
        n_checks++; if ({z_hi, z_lo} !== {32'd2, 32'd14}) begin n_fail++; $display("FAIL div_100_7: got %h %h expected 00000002 0000000e", z_hi, z_lo); end
        run_op(4'hC, 32'd17, 32'hFFFF_FFFB, 0, lat, bs, bd);
        n_checks++; if ({z_hi, z_lo} !== {32'd2, 32'hFFFF_FFFD}) begin n_fail++; $display("FAIL div_17_m5: got %h %h expected 00000002 fffffffd", z_hi, z_lo); end
`else
        run_op(4'hC, 32'hFFFF_FFEF, 32'd5, 0, lat, bs, bd);
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL nodiv_latency: got %0d expected 2", lat); end
        n_checks++; if ({z_hi, z_lo, err} !== {64'h0, 1'b1}) begin n_fail++; $display("FAIL nodiv_illegal: got %h %h err %b expected 0 0 err 1", z_hi, z_lo, err); end
        run_op(4'hC, 32'd9, 32'd0, 0, lat, bs, bd);
        n_checks++; if ({z_hi, z_lo, err} !== {64'h0, 1'b1}) begin n_fail++; $display("FAIL nodiv_div0: got %h %h err %b expected 0 0 err 1", z_hi, z_lo, err); end
`endif
    endtask

    task automatic test_mul();
        int lat, ndone;
        logic bs, bd;
        run_op(4'hB, 32'hFFFF_FFF9, 32'd6, 12, lat, bs, bd);
        n_checks++; if (lat !== 35) begin n_fail++; $display("FAIL mul_latency: got %0d expected 35", lat); end
        n_checks++; if ({z_hi, z_lo, err} !== {64'hFFFF_FFFF_FFFF_FFD6, 1'b0}) begin n_fail++; $display("FAIL mul_m7_6: got %h %h err %b expected ffffffff ffffffd6 err 0", z_hi, z_lo, err); end
        n_checks++; if ({bs, bd} !== 2'b10) begin n_fail++; $display("FAIL mul_busy: got %b expected 10", {bs, bd}); end
        ndone = 0;
        repeat (6) begin
            @(posedge clock); #1;
            if (done) ndone++;
        end
        n_checks++; if (ndone !== 0) begin n_fail++; $display("FAIL mul_poke_ignored: got %0d extra done expected 0", ndone); end
        run_op(4'hB, 32'h8000_0000, 32'h8000_0000, 0, lat, bs, bd);
        n_checks++; if ({z_hi, z_lo} !== 64'h4000_0000_0000_0000) begin n_fail++; $display("FAIL mul_min_min: got %h%h expected 4000000000000000", z_hi, z_lo); end
        run_op(4'hB, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, lat, bs, bd);
        n_checks++; if ({z_hi, z_lo} !== 64'h1) begin n_fail++; $display("FAIL mul_m1_m1: got %h%h expected 0000000000000001", z_hi, z_lo); end
        run_op(4'hB, 32'h0001_0000, 32'h0001_0000, 0, lat, bs, bd);
        n_checks++; if ({z_hi, z_lo} !== 64'h1_0000_0000) begin n_fail++; $display("FAIL mul_2p16_sq: got %h%h expected 0000000100000000", z_hi, z_lo); end
    endtask

    task automatic test_ops();
        int lat;
        logic bs, bd;
        logic [3:0]  t_op [13];
        logic [31:0] t_a  [13];
        logic [31:0] t_b  [13];
        logic [31:0] t_z  [13];
        t_op = '{4'h5, 4'h6, 4'h6, 4'h4, 4'h5, 4'h0, 4'h1, 4'h2, 4'h3, 4'h9, 4'hA, 4'h9, 4'h4};
        t_a  = '{32'h8000_0000, 32'h1, 32'h1, 32'h8000_0000, 32'h4000_0000, 32'hFFFF_FFFF, 32'h3,
                 32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'h5, 32'h0, 32'h8000_0000, 32'h1234_5678};
        t_b  = '{32'd4, 32'd32, 32'd5, 32'd4, 32'd4, 32'h2, 32'h5,
                 32'h3C3C_3C3C, 32'h0F0F_0F0F, 32'd12345, 32'h77, 32'h1, 32'd36};
        t_z  = '{32'hF800_0000, 32'h1, 32'h20, 32'h0800_0000, 32'h0400_0000, 32'h1, 32'hFFFF_FFFE,
                 32'h3030_3030, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0123_4567};
        for (int i = 0; i < 13; i++) begin
            run_op(t_op[i], t_a[i], t_b[i], 0, lat, bs, bd);
            n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL op_latency[%0d]: got %0d expected 2", i, lat); end
            n_checks++; if ({z_hi, z_lo, err} !== {32'h0, t_z[i], 1'b0}) begin n_fail++; $display("FAIL op[%0d]: got %h %h err %b expected 00000000 %h err 0", i, z_hi, z_lo, err, t_z[i]); end
        end
    endtask

    task automatic test_illegal();
        int lat;
        logic bs, bd;
        run_op(4'hE, 32'd123, 32'd456, 0, lat, bs, bd);
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL illegal_latency: got %0d expected 2", lat); end
        n_checks++; if ({z_hi, z_lo, err} !== {64'h0, 1'b1}) begin n_fail++; $display("FAIL illegal_E: got %h %h err %b expected 0 0 err 1", z_hi, z_lo, err); end
        run_op(4'hF, 32'd1, 32'd2, 0, lat, bs, bd);
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL illegal_F: got err %b expected 1", err); end
        run_op(4'h0, 32'd1, 32'd1, 0, lat, bs, bd);
        n_checks++; if ({z_lo, err} !== {32'd2, 1'b0}) begin n_fail++; $display("FAIL err_clears: got %h err %b expected 00000002 err 0", z_lo, err); end
    endtask

    task automatic test_back_to_back();
        int ndone, last, gap_bad;
        @(posedge clock); #1;
        opcode = 4'h0; a_in = 32'd1; b_in = 32'd2; start = 1'b1;
        ndone = 0; last = -1; gap_bad = 0;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clock); #1;
            if (done) begin
                if (last >= 0 && (c - last) != 3) gap_bad++;
                if (z_lo !== 32'd3 || busy !== 1'b0) gap_bad++;
                last = c;
                ndone++;
            end
        end
        start = 1'b0;
        n_checks++; if (ndone !== 10) begin n_fail++; $display("FAIL b2b_done_count: got %0d expected 10", ndone); end
        n_checks++; if (gap_bad !== 0) begin n_fail++; $display("FAIL b2b_spacing: got %0d bad pulses expected 0", gap_bad); end
    endtask

    initial begin
        clear_n = 1'b0; start = 1'b0; opcode = 4'h0; a_in = '0; b_in = '0;
        test_reset();
        test_rotate();
        test_div();
        test_mul();
        test_ops();
        test_illegal();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end
endmodule
